// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types, opcode constants and forwarding encodings.
package pipe_ctrl_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_NOP   = 6'b111111;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic             valid;
    logic             rw;
    logic             mtr;
    logic [REG_W-1:0] dest;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_NOP = '0;

  // Operand source select; the younger MEM-slot producer shadows the WB-slot one.
  function automatic logic [FWD_W-1:0] fwdSelect(
    input logic             used,
    input logic [REG_W-1:0] src,
    input logic             memWr,
    input logic [REG_W-1:0] memDest,
    input logic             wbWr,
    input logic [REG_W-1:0] wbDest
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (used && memWr && (memDest != '0) && (memDest == src)) begin
      sel = FWD_EXMEM;
    end else if (used && wbWr && (wbDest != '0) && (wbDest == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// ID-stage control decode: write-back controls, destination and source usage.
module id_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  output logic             rw,
  output logic             mtr,
  output logic [REG_W-1:0] dest,
  output logic             usesRs,
  output logic             usesRt,
  output logic             isJump
);

  // Opcode decode; unknown opcodes fall through as harmless non-writers.
  always_comb begin
    rw     = 1'b0;
    mtr    = 1'b0;
    dest   = '0;
    usesRs = 1'b0;
    usesRt = 1'b0;
    isJump = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rw     = 1'b1;
        dest   = rd;
        usesRs = 1'b1;
        usesRt = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        rw     = 1'b1;
        dest   = rt;
        usesRs = 1'b1;
      end
      OP_LW: begin
        rw     = 1'b1;
        mtr    = 1'b1;
        dest   = rt;
        usesRs = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        usesRs = 1'b1;
        usesRt = 1'b1;
      end
      OP_J: begin
        isJump = 1'b1;
      end
      default: begin
      end
    endcase
    // $0 is hardwired; a write to it is never a real producer
    if (dest == '0) begin
      rw = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_wb_sequencer.sv
// Write-back control pipeline with load-use stall, branch/jump flush and forwarding selects.
module hazard_wb_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_br_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_dest,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             idRw;
  logic             idMtr;
  logic [REG_W-1:0] idDest;
  logic             idUsesRs;
  logic             idUsesRt;
  logic             idIsJump;
  stage_ctrl_t      idSlot;

  stage_ctrl_t      exSlot;
  stage_ctrl_t      memSlot;
  logic             exUsesRs;
  logic             exUsesRt;
  logic [REG_W-1:0] exRs;
  logic [REG_W-1:0] exRt;

  logic             loadUse;
  logic             luStall;

  id_ctrl_decode u_decode (
    .opcode (id_opcode),
    .rt     (id_rt),
    .rd     (id_rd),
    .rw     (idRw),
    .mtr    (idMtr),
    .dest   (idDest),
    .usesRs (idUsesRs),
    .usesRt (idUsesRt),
    .isJump (idIsJump)
  );

  // Control bundle the ID instruction would carry into EX.
  always_comb begin
    idSlot       = STAGE_NOP;
    idSlot.valid = (id_opcode != OP_NOP);
    idSlot.rw    = idRw;
    idSlot.mtr   = idMtr;
    idSlot.dest  = idDest;
  end

  // A load in EX whose destination the ID instruction reads.
  always_comb begin
    loadUse = exSlot.valid && exSlot.rw && exSlot.mtr && (exSlot.dest != '0) &&
              ((idUsesRs && (id_rs == exSlot.dest)) ||
               (idUsesRt && (id_rt == exSlot.dest)));
  end

  // Hazard priority: reset, memory stall, taken branch, load-use, jump.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    luStall     = 1'b0;
    if (!rst_n) begin
      pc_write = 1'b1;
    end else if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (loadUse) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      luStall     = 1'b1;
    end else if (idIsJump) begin
      ifid_flush = 1'b1;
    end
  end

  // Stage slots and write-back outputs advance together unless memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exSlot      <= STAGE_NOP;
      memSlot     <= STAGE_NOP;
      exUsesRs    <= 1'b0;
      exUsesRt    <= 1'b0;
      exRs        <= '0;
      exRt        <= '0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_dest     <= '0;
    end else if (!mem_stall) begin
      wb_regwrite <= memSlot.valid & memSlot.rw;
      wb_memtoreg <= memSlot.mtr;
      wb_dest     <= memSlot.dest;
      memSlot     <= exSlot;
      if (idex_bubble) begin
        exSlot   <= STAGE_NOP;
        exUsesRs <= 1'b0;
        exUsesRt <= 1'b0;
        exRs     <= '0;
        exRt     <= '0;
      end else begin
        exSlot   <= idSlot;
        exUsesRs <= idUsesRs;
        exUsesRt <= idUsesRt;
        exRs     <= id_rs;
        exRt     <= id_rt;
      end
    end
  end

  // ALU operand selects for the instruction currently in EX.
  always_comb begin
    fwd_a = fwdSelect(exUsesRs, exRs, memSlot.valid & memSlot.rw, memSlot.dest,
                      wb_regwrite, wb_dest);
    fwd_b = fwdSelect(exUsesRt, exRt, memSlot.valid & memSlot.rw, memSlot.dest,
                      wb_regwrite, wb_dest);
  end

  // Saturating performance counters for load-use stalls and front-end flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (luStall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_wb_sequencer.sv
// Directed bench for hazard_wb_sequencer: vector table plus stall/reset/saturation sequences.
module tb_hazard_wb_sequencer;
  import pipe_ctrl_pkg::*;

  localparam int unsigned NVEC = 24;
  localparam logic [3:0] C_NORM = 4'b1100;  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] C_LU   = 4'b0001;
  localparam logic [3:0] C_JMP  = 4'b1110;
  localparam logic [3:0] C_BR   = 4'b1111;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        br;
    logic [3:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        wrw;
    logic [4:0]  wd;
    logic [15:0] st;
    logic [15:0] fc;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic [5:0]  idOpcode;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic [4:0]  idRd;
  logic        exBrTaken;
  logic        memStall;

  logic        pcWrite, ifidWrite, ifidFlush, idexBubble;
  logic [1:0]  fwdA, fwdB;
  logic        wbRegwrite, wbMemtoreg;
  logic [4:0]  wbDest;
  logic [15:0] stallCnt, flushCnt;

  logic        sPcWrite, sIfidWrite, sIfidFlush, sIdexBubble;
  logic [1:0]  sFwdA, sFwdB;
  logic        sWbRegwrite, sWbMemtoreg;
  logic [4:0]  sWbDest;
  logic [3:0]  sStallCnt, sFlushCnt;

  int nChecks = 0;
  int nFails  = 0;
  vec_t vecs [NVEC];

  hazard_wb_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rstN), .id_opcode(idOpcode), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
    .ex_br_taken(exBrTaken), .mem_stall(memStall), .pc_write(pcWrite), .ifid_write(ifidWrite),
    .ifid_flush(ifidFlush), .idex_bubble(idexBubble), .fwd_a(fwdA), .fwd_b(fwdB),
    .wb_regwrite(wbRegwrite), .wb_memtoreg(wbMemtoreg), .wb_dest(wbDest),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  hazard_wb_sequencer #(.CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rstN), .id_opcode(idOpcode), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
    .ex_br_taken(exBrTaken), .mem_stall(memStall), .pc_write(sPcWrite), .ifid_write(sIfidWrite),
    .ifid_flush(sIfidFlush), .idex_bubble(sIdexBubble), .fwd_a(sFwdA), .fwd_b(sFwdB),
    .wb_regwrite(sWbRegwrite), .wb_memtoreg(sWbMemtoreg), .wb_dest(sWbDest),
    .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic br, input logic [3:0] ctl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic wrw,
                              input logic [4:0] wd, input logic [15:0] st, input logic [15:0] fc);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.br = br; v.ctl = ctl;
    v.fa = fa; v.fb = fb; v.wrw = wrw; v.wd = wd; v.st = st; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    idOpcode = op; idRs = rs; idRt = rt; idRd = rd;
  endtask

  task automatic checkResetTable(input string tag);
    check({tag, " pc_write"}, 16'(pcWrite), 16'd1);
    check({tag, " ifid_write"}, 16'(ifidWrite), 16'd1);
    check({tag, " ifid_flush"}, 16'(ifidFlush), 16'd0);
    check({tag, " idex_bubble"}, 16'(idexBubble), 16'd0);
    check({tag, " fwd_a"}, 16'(fwdA), 16'd0);
    check({tag, " fwd_b"}, 16'(fwdB), 16'd0);
    check({tag, " wb_regwrite"}, 16'(wbRegwrite), 16'd0);
    check({tag, " wb_memtoreg"}, 16'(wbMemtoreg), 16'd0);
    check({tag, " wb_dest"}, 16'(wbDest), 16'd0);
    check({tag, " stall_cnt"}, stallCnt, 16'd0);
    check({tag, " flush_cnt"}, flushCnt, 16'd0);
  endtask

  initial begin
    vecs[0]  = mk(OP_LW,    5'd1, 5'd5, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd0, 16'd0);
    vecs[1]  = mk(OP_RTYPE, 5'd5, 5'd7, 5'd6,  1'b0, C_LU,   FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd0, 16'd0);
    vecs[2]  = mk(OP_RTYPE, 5'd5, 5'd7, 5'd6,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[3]  = mk(OP_RTYPE, 5'd1, 5'd2, 5'd3,  1'b0, C_NORM, FWD_MEMWB, FWD_RF,    1'b1, 5'd5,  16'd1, 16'd0);
    vecs[4]  = mk(OP_RTYPE, 5'd3, 5'd3, 5'd4,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[5]  = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_EXMEM, FWD_EXMEM, 1'b1, 5'd6,  16'd1, 16'd0);
    vecs[6]  = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b1, 5'd3,  16'd1, 16'd0);
    vecs[7]  = mk(OP_RTYPE, 5'd1, 5'd2, 5'd3,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b1, 5'd4,  16'd1, 16'd0);
    vecs[8]  = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[9]  = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[10] = mk(OP_RTYPE, 5'd3, 5'd0, 5'd8,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b1, 5'd3,  16'd1, 16'd0);
    vecs[11] = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[12] = mk(OP_RTYPE, 5'd1, 5'd2, 5'd3,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[13] = mk(OP_RTYPE, 5'd4, 5'd5, 5'd3,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b1, 5'd8,  16'd1, 16'd0);
    vecs[14] = mk(OP_RTYPE, 5'd3, 5'd9, 5'd10, 1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[15] = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_EXMEM, FWD_RF,    1'b1, 5'd3,  16'd1, 16'd0);
    vecs[16] = mk(OP_ADDI,  5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b1, 5'd3,  16'd1, 16'd0);
    vecs[17] = mk(OP_RTYPE, 5'd0, 5'd0, 5'd11, 1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b1, 5'd10, 16'd1, 16'd0);
    vecs[18] = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[19] = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd0);
    vecs[20] = mk(OP_J,     5'd3, 5'd4, 5'd0,  1'b0, C_JMP,  FWD_RF,    FWD_RF,    1'b1, 5'd11, 16'd1, 16'd0);
    vecs[21] = mk(OP_LW,    5'd1, 5'd5, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd1);
    vecs[22] = mk(OP_RTYPE, 5'd5, 5'd7, 5'd6,  1'b1, C_BR,   FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd1);
    vecs[23] = mk(OP_NOP,   5'd0, 5'd0, 5'd0,  1'b0, C_NORM, FWD_RF,    FWD_RF,    1'b0, 5'd0,  16'd1, 16'd2);

    // reset state, checked before any clock edge
    rstN = 1'b0; exBrTaken = 1'b0; memStall = 1'b0;
    setId(OP_NOP, 5'd0, 5'd0, 5'd0);
    #3;
    checkResetTable("reset");
    tick();
    tick();
    rstN = 1'b1;

    // one row per cycle from a clean pipeline
    for (int i = 0; i < int'(NVEC); i++) begin
      setId(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      exBrTaken = vecs[i].br;
      #1;
      check($sformatf("r%0d pc_write", i),    16'(pcWrite),    16'(vecs[i].ctl[3]));
      check($sformatf("r%0d ifid_write", i),  16'(ifidWrite),  16'(vecs[i].ctl[2]));
      check($sformatf("r%0d ifid_flush", i),  16'(ifidFlush),  16'(vecs[i].ctl[1]));
      check($sformatf("r%0d idex_bubble", i), 16'(idexBubble), 16'(vecs[i].ctl[0]));
      check($sformatf("r%0d fwd_a", i),       16'(fwdA),       16'(vecs[i].fa));
      check($sformatf("r%0d fwd_b", i),       16'(fwdB),       16'(vecs[i].fb));
      check($sformatf("r%0d wb_regwrite", i), 16'(wbRegwrite), 16'(vecs[i].wrw));
      check($sformatf("r%0d wb_dest", i),     16'(wbDest),     16'(vecs[i].wd));
      check($sformatf("r%0d stall_cnt", i),   stallCnt,        vecs[i].st);
      check($sformatf("r%0d flush_cnt", i),   flushCnt,        vecs[i].fc);
      tick();
    end
    exBrTaken = 1'b0;

    // memory stall held three cycles over a pending load-use
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    setId(OP_LW, 5'd1, 5'd5, 5'd0);
    tick();
    setId(OP_RTYPE, 5'd5, 5'd7, 5'd6);
    memStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exBrTaken = (k == 1);
      #1;
      check($sformatf("ms%0d pc_write", k),    16'(pcWrite),    16'd0);
      check($sformatf("ms%0d ifid_write", k),  16'(ifidWrite),  16'd0);
      check($sformatf("ms%0d ifid_flush", k),  16'(ifidFlush),  16'd0);
      check($sformatf("ms%0d idex_bubble", k), 16'(idexBubble), 16'd0);
      check($sformatf("ms%0d stall_cnt", k),   stallCnt,        16'd0);
      tick();
    end
    memStall = 1'b0;
    exBrTaken = 1'b0;
    #1;
    check("ms release pc_write", 16'(pcWrite), 16'd0);
    check("ms release idex_bubble", 16'(idexBubble), 16'd1);
    tick();
    check("ms after pc_write", 16'(pcWrite), 16'd1);
    check("ms after idex_bubble", 16'(idexBubble), 16'd0);
    check("ms after stall_cnt", stallCnt, 16'd1);

    // reset dropped in the middle of a branch flush
    setId(OP_J, 5'd0, 5'd0, 5'd0);
    tick();
    setId(OP_NOP, 5'd0, 5'd0, 5'd0);
    exBrTaken = 1'b1;
    #1;
    check("mid-flush ifid_flush", 16'(ifidFlush), 16'd1);
    check("mid-flush flush_cnt", flushCnt, 16'd1);
    rstN = 1'b0;
    #1;
    checkResetTable("async reset");
    exBrTaken = 1'b0;
    tick();
    rstN = 1'b1;

    // back-to-back lw $5,($5): a stall every other cycle, 20 in 40 cycles
    setId(OP_LW, 5'd5, 5'd5, 5'd0);
    repeat (40) tick();
    check("sat16 stall_cnt", stallCnt, 16'd20);
    check("sat4 stall_cnt", 16'(sStallCnt), 16'hF);
    check("sat4 flush_cnt", 16'(sFlushCnt), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
